// File: rtl/cpu.sv
// rtl/cpu.sv - five-stage in-order RV32I pipeline with forwarding, load-use interlock and busywait freeze
`timescale 1ns/1ps

module cpu_reg_file (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2
);
  logic [31:0] REGISTERS [0:31];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < 32; i++) REGISTERS[i] <= 32'd0;
    end else if (i_we && i_waddr != 5'd0) begin
      REGISTERS[i_waddr] <= i_wdata;
    end
  end

  // Write-through: a read of the register WB commits this cycle returns the new value
  always_comb begin
    o_rdata1 = REGISTERS[i_raddr1];
    o_rdata2 = REGISTERS[i_raddr2];
    if (i_raddr1 == 5'd0) o_rdata1 = 32'd0;
    else if (i_we && i_waddr == i_raddr1) o_rdata1 = i_wdata;
    if (i_raddr2 == 5'd0) o_rdata2 = 32'd0;
    else if (i_we && i_waddr == i_raddr2) o_rdata2 = i_wdata;
  end
endmodule

module cpu (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [31:0] INSTRUCTION,
  output logic [3:0]  DATA_MEM_READ,
  output logic [2:0]  DATA_MEM_WRITE,
  output logic [31:0] DATA_MEM_ADDR,
  output logic [31:0] DATA_MEM_WRITE_DATA,
  input  logic [31:0] DATA_MEM_READ_DATA,
  input  logic        DATA_MEM_BUSYWAIT,
  input  logic        INSTR_MEM_BUSYWAIT
);
  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_OP     = 7'b0110011;

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr, r_ifid_pc;
  logic [31:0] r_idex_instr, r_idex_pc, r_idex_rs1_val, r_idex_rs2_val;
  logic [31:0] r_exmem_result, r_exmem_store_data;
  logic [4:0]  r_exmem_rd;
  logic [2:0]  r_exmem_funct3;
  logic        r_exmem_reg_write, r_exmem_mem_read, r_exmem_mem_write;
  logic [31:0] r_memwb_result;
  logic [4:0]  r_memwb_rd;
  logic        r_memwb_reg_write;

  logic        w_stall, w_load_use, w_rf_we;
  logic [31:0] w_rf_rdata1, w_rf_rdata2;

  assign w_stall = DATA_MEM_BUSYWAIT | INSTR_MEM_BUSYWAIT;
  assign w_rf_we = r_memwb_reg_write & ~w_stall;

  cpu_reg_file ID_REG_FILE (
    .i_clk    (CLK),
    .i_resetn (RESET),
    .i_we     (w_rf_we),
    .i_waddr  (r_memwb_rd),
    .i_wdata  (r_memwb_result),
    .i_raddr1 (r_ifid_instr[19:15]),
    .i_raddr2 (r_ifid_instr[24:20]),
    .o_rdata1 (w_rf_rdata1),
    .o_rdata2 (w_rf_rdata2)
  );

  // ID: which source fields the instruction really reads, for the load-use interlock
  logic [6:0] w_id_opcode;
  logic       w_id_uses_rs1, w_id_uses_rs2;
  assign w_id_opcode   = r_ifid_instr[6:0];
  assign w_id_uses_rs1 = (w_id_opcode == OP_JALR) || (w_id_opcode == OP_BRANCH) ||
                         (w_id_opcode == OP_LOAD) || (w_id_opcode == OP_STORE) ||
                         (w_id_opcode == OP_IMM)  || (w_id_opcode == OP_OP);
  assign w_id_uses_rs2 = (w_id_opcode == OP_BRANCH) || (w_id_opcode == OP_STORE) ||
                         (w_id_opcode == OP_OP);

  // EX decode
  logic [6:0]  w_ex_opcode;
  logic [4:0]  w_ex_rd, w_ex_rs1, w_ex_rs2;
  logic [2:0]  w_ex_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  assign w_ex_opcode = r_idex_instr[6:0];
  assign w_ex_rd     = r_idex_instr[11:7];
  assign w_ex_f3     = r_idex_instr[14:12];
  assign w_ex_rs1    = r_idex_instr[19:15];
  assign w_ex_rs2    = r_idex_instr[24:20];
  assign w_imm_i = {{20{r_idex_instr[31]}}, r_idex_instr[31:20]};
  assign w_imm_s = {{20{r_idex_instr[31]}}, r_idex_instr[31:25], r_idex_instr[11:7]};
  assign w_imm_b = {{19{r_idex_instr[31]}}, r_idex_instr[31], r_idex_instr[7],
                    r_idex_instr[30:25], r_idex_instr[11:8], 1'b0};
  assign w_imm_u = {r_idex_instr[31:12], 12'd0};
  assign w_imm_j = {{11{r_idex_instr[31]}}, r_idex_instr[31], r_idex_instr[19:12],
                    r_idex_instr[20], r_idex_instr[30:21], 1'b0};

  assign w_load_use = (w_ex_opcode == OP_LOAD) && (w_ex_rd != 5'd0) &&
                      ((w_id_uses_rs1 && r_ifid_instr[19:15] == w_ex_rd) ||
                       (w_id_uses_rs2 && r_ifid_instr[24:20] == w_ex_rd));

  logic [31:0] w_fwd_a, w_fwd_b;
  always_comb begin
    w_fwd_a = r_idex_rs1_val;
    w_fwd_b = r_idex_rs2_val;
    if (w_ex_rs1 != 5'd0 && r_exmem_reg_write && r_exmem_rd == w_ex_rs1) w_fwd_a = r_exmem_result;
    else if (w_ex_rs1 != 5'd0 && r_memwb_reg_write && r_memwb_rd == w_ex_rs1) w_fwd_a = r_memwb_result;
    if (w_ex_rs2 != 5'd0 && r_exmem_reg_write && r_exmem_rd == w_ex_rs2) w_fwd_b = r_exmem_result;
    else if (w_ex_rs2 != 5'd0 && r_memwb_reg_write && r_memwb_rd == w_ex_rs2) w_fwd_b = r_memwb_result;
  end

  function automatic logic [31:0] alu_op(input logic [2:0] f3, input logic alt,
                                         input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  alu_op = alt ? (a - b) : (a + b);
      3'b001:  alu_op = a << b[4:0];
      3'b010:  alu_op = {31'd0, $signed(a) < $signed(b)};
      3'b011:  alu_op = {31'd0, a < b};
      3'b100:  alu_op = a ^ b;
      3'b101:  alu_op = alt ? $unsigned($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  alu_op = a | b;
      default: alu_op = a & b;
    endcase
  endfunction

  logic [31:0] w_ex_result, w_ex_target, w_jalr_sum;
  logic        w_ex_reg_write, w_ex_mem_read, w_ex_mem_write, w_ex_taken;
  assign w_jalr_sum = w_fwd_a + w_imm_i;

  always_comb begin
    w_ex_result    = 32'd0;
    w_ex_reg_write = 1'b0;
    w_ex_mem_read  = 1'b0;
    w_ex_mem_write = 1'b0;
    w_ex_taken     = 1'b0;
    w_ex_target    = r_idex_pc + w_imm_b;
    case (w_ex_opcode)
      OP_LUI:   begin w_ex_result = w_imm_u; w_ex_reg_write = 1'b1; end
      OP_AUIPC: begin w_ex_result = r_idex_pc + w_imm_u; w_ex_reg_write = 1'b1; end
      OP_JAL: begin
        w_ex_result = r_idex_pc + 32'd4; w_ex_reg_write = 1'b1;
        w_ex_taken = 1'b1; w_ex_target = r_idex_pc + w_imm_j;
      end
      OP_JALR: begin
        w_ex_result = r_idex_pc + 32'd4; w_ex_reg_write = 1'b1;
        w_ex_taken = 1'b1; w_ex_target = w_jalr_sum & ~32'd1;
      end
      OP_BRANCH: begin
        case (w_ex_f3)
          3'b000:  w_ex_taken = (w_fwd_a == w_fwd_b);
          3'b001:  w_ex_taken = (w_fwd_a != w_fwd_b);
          3'b100:  w_ex_taken = ($signed(w_fwd_a) < $signed(w_fwd_b));
          3'b101:  w_ex_taken = ($signed(w_fwd_a) >= $signed(w_fwd_b));
          3'b110:  w_ex_taken = (w_fwd_a < w_fwd_b);
          3'b111:  w_ex_taken = (w_fwd_a >= w_fwd_b);
          default: w_ex_taken = 1'b0;
        endcase
      end
      OP_LOAD:  begin w_ex_result = w_fwd_a + w_imm_i; w_ex_reg_write = 1'b1; w_ex_mem_read = 1'b1; end
      OP_STORE: begin w_ex_result = w_fwd_a + w_imm_s; w_ex_mem_write = 1'b1; end
      OP_IMM: begin
        w_ex_result = alu_op(w_ex_f3, (w_ex_f3 == 3'b101) && r_idex_instr[30], w_fwd_a, w_imm_i);
        w_ex_reg_write = 1'b1;
      end
      OP_OP: begin
        w_ex_result = alu_op(w_ex_f3, r_idex_instr[30], w_fwd_a, w_fwd_b);
        w_ex_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_pc               <= 32'd0;
      r_ifid_instr       <= NOP;
      r_ifid_pc          <= 32'd0;
      r_idex_instr       <= NOP;
      r_idex_pc          <= 32'd0;
      r_idex_rs1_val     <= 32'd0;
      r_idex_rs2_val     <= 32'd0;
      r_exmem_result     <= 32'd0;
      r_exmem_store_data <= 32'd0;
      r_exmem_rd         <= 5'd0;
      r_exmem_funct3     <= 3'd0;
      r_exmem_reg_write  <= 1'b0;
      r_exmem_mem_read   <= 1'b0;
      r_exmem_mem_write  <= 1'b0;
      r_memwb_result     <= 32'd0;
      r_memwb_rd         <= 5'd0;
      r_memwb_reg_write  <= 1'b0;
    end else if (!w_stall) begin
      if (w_ex_taken) begin
        r_pc         <= w_ex_target;
        r_ifid_instr <= NOP;
        r_idex_instr <= NOP;
      end else if (w_load_use) begin
        r_idex_instr <= NOP;
      end else begin
        r_pc           <= r_pc + 32'd4;
        r_ifid_instr   <= INSTRUCTION;
        r_ifid_pc      <= r_pc;
        r_idex_instr   <= r_ifid_instr;
        r_idex_pc      <= r_ifid_pc;
        r_idex_rs1_val <= w_rf_rdata1;
        r_idex_rs2_val <= w_rf_rdata2;
      end
      r_exmem_result     <= w_ex_result;
      r_exmem_store_data <= w_fwd_b;
      r_exmem_rd         <= w_ex_rd;
      r_exmem_funct3     <= w_ex_f3;
      r_exmem_reg_write  <= w_ex_reg_write;
      r_exmem_mem_read   <= w_ex_mem_read;
      r_exmem_mem_write  <= w_ex_mem_write;
      r_memwb_result     <= r_exmem_mem_read ? DATA_MEM_READ_DATA : r_exmem_result;
      r_memwb_rd         <= r_exmem_rd;
      r_memwb_reg_write  <= r_exmem_reg_write;
    end
  end

  assign PC                  = r_pc;
  assign DATA_MEM_READ       = {r_exmem_mem_read, r_exmem_funct3};
  assign DATA_MEM_WRITE      = {r_exmem_mem_write, r_exmem_funct3[1:0]};
  assign DATA_MEM_ADDR       = r_exmem_result;
  assign DATA_MEM_WRITE_DATA = r_exmem_store_data;
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - directed program tests for the cpu pipeline
`timescale 1ns/1ps

module tb_cpu;
  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic [31:0] PC;
  logic [31:0] INSTRUCTION;
  logic [3:0]  DATA_MEM_READ;
  logic [2:0]  DATA_MEM_WRITE;
  logic [31:0] DATA_MEM_ADDR;
  logic [31:0] DATA_MEM_WRITE_DATA;
  logic [31:0] DATA_MEM_READ_DATA;
  logic        DATA_MEM_BUSYWAIT = 1'b0;
  logic        INSTR_MEM_BUSYWAIT = 1'b0;

  logic [31:0] imem [0:63];
  int n_tests = 0;
  int n_fail  = 0;

  cpu dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .PC                  (PC),
    .INSTRUCTION         (INSTRUCTION),
    .DATA_MEM_READ       (DATA_MEM_READ),
    .DATA_MEM_WRITE      (DATA_MEM_WRITE),
    .DATA_MEM_ADDR       (DATA_MEM_ADDR),
    .DATA_MEM_WRITE_DATA (DATA_MEM_WRITE_DATA),
    .DATA_MEM_READ_DATA  (DATA_MEM_READ_DATA),
    .DATA_MEM_BUSYWAIT   (DATA_MEM_BUSYWAIT),
    .INSTR_MEM_BUSYWAIT  (INSTR_MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  assign INSTRUCTION        = imem[PC[7:2]];
  assign DATA_MEM_READ_DATA = (DATA_MEM_ADDR == 32'd8) ? 32'h1234_5678 : 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] xreg(input int i);
    return dut.ID_REG_FILE.REGISTERS[i];
  endfunction

  function automatic logic [31:0] mem_en();
    return {30'd0, DATA_MEM_READ[3], DATA_MEM_WRITE[2]};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < 64; i++) imem[i] = w;
  endtask

  task automatic do_reset();
    RESET = 1'b0;
    DATA_MEM_BUSYWAIT = 1'b0;
    INSTR_MEM_BUSYWAIT = 1'b0;
    step(2);
    RESET = 1'b1;
  endtask

  initial begin
    // reset state
    fill(32'h0000_0013);
    do_reset();
    check_eq("reset_pc", PC, 32'd0);
    check_eq("reset_mem_en", mem_en(), 32'd0);
    check_eq("reset_x1", xreg(1), 32'd0);

    // LUI x1,0x1 held on the bus
    fill(32'h0000_10B7);
    do_reset();
    step(4);
    check_eq("lui_pc16", PC, 32'd16);
    step(1);
    check_eq("lui_x1", xreg(1), 32'h0000_1000);
    check_eq("lui_x2", xreg(2), 32'd0);
    check_eq("lui_mem_en", mem_en(), 32'd0);

    // ADDI x3,x0,7 held; reset mid-run must clear x1 from before
    fill(32'h0070_0193);
    do_reset();
    check_eq("rst_clears_x1", xreg(1), 32'd0);
    step(4);
    check_eq("addi_pc16", PC, 32'd16);
    step(1);
    check_eq("addi_x3", xreg(3), 32'd7);
    check_eq("addi_x1", xreg(1), 32'd0);
    check_eq("addi_mem_en", mem_en(), 32'd0);

    // ADDI x1,x0,5 ; ADD x2,x1,x1 -- forwarded, no bubble
    fill(32'h0000_0013);
    imem[0] = 32'h0050_0093;
    imem[1] = 32'h0010_8133;
    do_reset();
    step(6);
    check_eq("fwd_x1", xreg(1), 32'd5);
    check_eq("fwd_x2", xreg(2), 32'd10);

    // LUI/ADDI build x2, SW x2,8(x0), LW x3,8(x0), dependent ADD x4,x3,x3
    fill(32'h0000_0013);
    imem[0] = 32'hDEAD_C137;
    imem[1] = 32'hEEF1_0113;
    imem[2] = 32'h0020_2423;
    imem[3] = 32'h0080_2183;
    imem[4] = 32'h0031_8233;
    do_reset();
    step(5);
    check_eq("sw_write", {29'd0, DATA_MEM_WRITE}, 32'd6);
    check_eq("sw_rd_en", {31'd0, DATA_MEM_READ[3]}, 32'd0);
    check_eq("sw_addr", DATA_MEM_ADDR, 32'd8);
    check_eq("sw_data", DATA_MEM_WRITE_DATA, 32'hDEAD_BEEF);
    step(1);
    check_eq("lw_read", {28'd0, DATA_MEM_READ}, 32'hA);
    check_eq("lw_wr_en", {31'd0, DATA_MEM_WRITE[2]}, 32'd0);
    check_eq("lw_addr", DATA_MEM_ADDR, 32'd8);
    step(2);
    check_eq("lw_x3", xreg(3), 32'h1234_5678);
    check_eq("x2_built", xreg(2), 32'hDEAD_BEEF);
    step(1);
    check_eq("loaduse_bubble_x4", xreg(4), 32'd0);
    step(1);
    check_eq("loaduse_x4", xreg(4), 32'h2468_ACF0);

    // BEQ x0,x0,+16 with two shadow ADDIs and a target ADDI
    fill(32'h0000_0013);
    imem[0] = 32'h0000_0863;
    imem[1] = 32'h0010_0293;
    imem[2] = 32'h0010_0313;
    imem[3] = 32'h0010_0393;
    imem[4] = 32'h0030_0413;
    do_reset();
    step(2);
    check_eq("beq_pc8", PC, 32'd8);
    step(1);
    check_eq("beq_pc16", PC, 32'd16);
    step(8);
    check_eq("beq_flush_x5", xreg(5), 32'd0);
    check_eq("beq_flush_x6", xreg(6), 32'd0);
    check_eq("beq_skip_x7", xreg(7), 32'd0);
    check_eq("beq_target_x8", xreg(8), 32'd3);

    // signed/unsigned compare, shifts, JAL link and flush
    fill(32'h0000_0013);
    imem[0] = 32'hFFF0_0093;
    imem[1] = 32'h0000_A113;
    imem[2] = 32'h0010_B193;
    imem[3] = 32'h4040_D213;
    imem[4] = 32'h01C0_D293;
    imem[5] = 32'h0080_036F;
    imem[6] = 32'h0090_0393;
    imem[7] = 32'h0010_0413;
    do_reset();
    step(15);
    check_eq("slti_x2", xreg(2), 32'd1);
    check_eq("sltiu_x3", xreg(3), 32'd0);
    check_eq("srai_x4", xreg(4), 32'hFFFF_FFFF);
    check_eq("srli_x5", xreg(5), 32'h0000_000F);
    check_eq("jal_link_x6", xreg(6), 32'd24);
    check_eq("jal_flush_x7", xreg(7), 32'd0);
    check_eq("jal_target_x8", xreg(8), 32'd1);

    // data busywait for 3 cycles while LW sits in MEM
    fill(32'h0000_0013);
    imem[0] = 32'h0070_0093;
    imem[1] = 32'h0080_2183;
    do_reset();
    step(4);
    check_eq("bw_lw_in_mem", {31'd0, DATA_MEM_READ[3]}, 32'd1);
    DATA_MEM_BUSYWAIT = 1'b1;
    step(3);
    check_eq("bw_pc_frozen", PC, 32'd16);
    check_eq("bw_x1_held", xreg(1), 32'd0);
    check_eq("bw_x3_held", xreg(3), 32'd0);
    DATA_MEM_BUSYWAIT = 1'b0;
    step(1);
    check_eq("bw_x1_after", xreg(1), 32'd7);
    check_eq("bw_pc20", PC, 32'd20);
    step(1);
    check_eq("bw_x3_after", xreg(3), 32'h1234_5678);
    check_eq("bw_pc24", PC, 32'd24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
